// File: rtl/mul16_seq_if.sv
// mul16_seq_if
//   Bundles the requester-side and consumer-side handshakes of mul16_seq.
//   Both sides use valid/ready: a transfer happens on a rising clk edge where
//   valid and ready are both high. The producer holds valid and its data
//   steady until that edge. The consumer may drive ready at any time.
//   Ports (signals):
//     start_valid  requester presents operands a/b
//     start_ready  multiplier can accept operands
//     a, b         16-bit multiplicand / multiplier
//     result_valid product available
//     result_ready consumer takes product
//     product      16-bit product a*b mod 2^16
//   Modports: master = requester/consumer side, slave = multiplier side.
interface mul16_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] product;

  modport master (
    output start_valid, a, b, result_ready,
    input  start_ready, result_valid, product
  );

  modport slave (
    input  start_valid, a, b, result_ready,
    output start_ready, result_valid, product
  );
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq
//   Sequential shift-and-add multiplier. It drives one shared add16 over
//   several cycles to form product = a * b[MBITS-1:0] mod 2^16. This is Hack
//   word semantics, so the result equals the low 16 bits of the signed
//   product when MBITS=16.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high; aborts any operation
//     bus        mul16_seq_if.slave (start/result valid-ready handshakes)
//     dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
//   Parameters:
//     MBITS  number of multiplier bits examined (1..16); b[15:MBITS] ignored
//     CNT_W  iteration counter width, must hold MBITS
//   Optional feature macro: MUL16_EARLY_EXIT_EN
//     When defined, RUN also finishes as soon as no set multiplier bits
//     remain. Latency is then 1 + index of the highest set bit of
//     b[MBITS-1:0], or 1 when that field is 0.

module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum
);
  // Carry out of bit 15 is dropped: word arithmetic wraps.
  assign sum = x + y;
endmodule

module mul16_seq #(
  parameter int MBITS = 16,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  mul16_seq_if.slave      bus,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Selects b[MBITS-1:0]; the upper multiplier bits are zeroed.
  localparam logic [15:0]      MASK = 16'((32'd1 << MBITS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MBITS - 1);

  logic [1:0]       state;
  logic [15:0]      acc;
  logic [15:0]      mcand;
  logic [15:0]      mplier;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      product_q;

  logic [15:0]      sum;
  logic [15:0]      acc_next;
  logic             run_last;

  // The single adder always sees acc and the current shifted multiplicand.
  add16 u_add (
    .x   (acc),
    .y   (mcand),
    .sum (sum)
  );

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = sum;
    end
  end

`ifdef MUL16_EARLY_EXIT_EN
  // Stop once the bit consumed this edge is the last set bit remaining.
  always_comb begin
    run_last = 1'b0;
    if ((cnt == LAST) || (mplier[15:1] == 15'd0)) begin
      run_last = 1'b1;
    end
  end
`else
  always_comb begin
    run_last = 1'b0;
    if (cnt == LAST) begin
      run_last = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= 16'd0;
      mcand     <= 16'd0;
      mplier    <= 16'd0;
      cnt       <= '0;
      product_q <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            acc    <= 16'd0;
            mcand  <= bus.a;
            mplier <= bus.b & MASK;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (run_last) begin
            // Capture the final sum here so product is stable for all of DONE.
            product_q <= acc_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ready only in IDLE, so a request cannot restart in the cycle DONE retires.
  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.product      = product_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq
//   Self-checking bench for mul16_seq (MBITS=16). The reference model is
//   plain integer multiplication plus a latency rule. Expected products
//   travel through a scoreboard queue.
module tb_mul16_seq;

  localparam int MBITS = 16;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  mul16_seq_if bus ();

  mul16_seq #(.MBITS(MBITS), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] mask_b(input logic [15:0] b);
    logic [15:0] m;
    m = 16'd0;
    for (int i = 0; i < MBITS; i++) m[i] = b[i];
    return m;
  endfunction

  function automatic logic [15:0] ref_product(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(mask_b(b));
    return p[15:0];
  endfunction

  function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL16_EARLY_EXIT_EN
    logic [15:0] m;
    int hi;
    m = mask_b(b);
    hi = 0;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
    return hi + 1;
`else
    return MBITS + 0 * int'(b[0]);
`endif
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge with the DUT idle. Returns just after the
  // negedge that follows the result handshake.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input int hold, input string name, output time t_acc);
    logic [15:0] got;
    logic [15:0] held;
    logic [15:0] expv;
    int lat;
    exp_q.push_back(ref_product(op_a, op_b));
    checks++;
    if (bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s start_ready_idle: got %b expected 1", name, bus.start_ready);
    end
    bus.a = op_a;
    bus.b = op_b;
    bus.start_valid = 1'b1;
    bus.result_ready = 1'b0;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.result_valid === 1'b1) break;
      checks++;
      if (bus.start_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s start_ready_busy: got %b expected 0", name, bus.start_ready);
      end
      if (lat >= TIMEOUT) begin
        failures++;
        $display("FAIL %s timeout: no result_valid after %0d cycles", name, lat);
        void'(exp_q.pop_front());
        bus.start_valid = 1'b0;
        bus.result_ready = 1'b0;
        return;
      end
      // Noise on the handshake inputs while busy must have no effect.
      bus.result_ready = 1'($urandom_range(0, 1));
      bus.start_valid  = 1'($urandom_range(0, 1));
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
    end
    checks++;
    if (lat != exp_lat(op_b)) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(op_b));
    end
    got = bus.product;
    held = got;
    bus.result_ready = 1'b0;
    repeat (hold) begin
      bus.start_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.product !== held || bus.start_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold: valid=%b product=%h ready=%b expected valid=1 product=%h ready=0",
                 name, bus.result_valid, bus.product, bus.start_ready, held);
      end
    end
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.result_ready = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s retire: valid=%b ready=%b expected valid=0 ready=1",
               name, bus.result_valid, bus.start_ready);
    end
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s product: got %h expected %h", name, got, expv);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b0;
    bus.a = 16'd0;
    bus.b = 16'd0;
    reset = 1'b1;
    #12;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.product !== 16'd0 || bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: valid=%b product=%h ready=%b expected 0/0000/1",
               bus.result_valid, bus.product, bus.start_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.product !== 16'd0 || bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: valid=%b product=%h ready=%b expected 0/0000/1",
               bus.result_valid, bus.product, bus.start_ready);
    end
  endtask

  task automatic test_directed();
    time t;
    run_op(16'd3, 16'd5, 0, "dir_3x5", t);
    run_op(16'hFFFF, 16'hFFFF, 0, "dir_m1xm1", t);
    run_op(16'h8000, 16'd2, 0, "dir_wrap", t);
    run_op(16'h0000, 16'hBEEF, 0, "dir_a0", t);
    run_op(16'h1234, 16'h0000, 0, "dir_b0", t);
    run_op(16'h1234, 16'h0001, 0, "dir_b1", t);
    run_op(16'h0003, 16'h8000, 0, "dir_bmsb", t);
  endtask

  task automatic test_backpressure();
    time t;
    run_op(16'd7, 16'd9, 10, "backpressure_7x9", t);
  endtask

  task automatic test_random();
    time t;
    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), $urandom_range(0, 3), "random", t);
    end
  endtask

  task automatic test_reset_mid_run();
    time t;
    bus.a = 16'd7;
    bus.b = 16'd9;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.product !== 16'd0 || bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_run: valid=%b product=%h ready=%b expected 0/0000/1",
               bus.result_valid, bus.product, bus.start_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    // No stale result may appear after the abort.
    repeat (MBITS + 2) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_pulse: got valid=%b expected 0", bus.result_valid);
      end
    end
    run_op(16'd2, 16'd4, 0, "after_reset_2x4", t);
  endtask

  task automatic test_reset_in_done();
    int n;
    time t;
    bus.a = 16'h0101;
    bus.b = 16'h0003;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.result_valid !== 1'b1 || bus.product !== 16'h0303) begin
      failures++;
      $display("FAIL done_before_reset: valid=%b product=%h expected 1/0303",
               bus.result_valid, bus.product);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.product !== 16'd0 || bus.start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_done: valid=%b product=%h ready=%b expected 0/0000/1",
               bus.result_valid, bus.product, bus.start_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(16'd11, 16'd13, 1, "after_done_reset", t);
  endtask

  task automatic test_back_to_back();
    time t0;
    time t1;
    logic [15:0] b0;
    b0 = 16'($urandom);
    run_op(16'($urandom), b0, 0, "b2b_first", t0);
    for (int i = 0; i < 5; i++) begin
      logic [15:0] bn;
      bn = 16'($urandom);
      run_op(16'($urandom), bn, 0, "b2b", t1);
      checks++;
      if ((t1 - t0) != time'((exp_lat(b0) + 2) * 10)) begin
        failures++;
        $display("FAIL b2b_spacing: got %0t expected %0d", t1 - t0, (exp_lat(b0) + 2) * 10);
      end
      t0 = t1;
      b0 = bn;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    test_reset_in_done();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
